// File: rtl/usb_bit_stuffer_if.sv
// usb_bit_stuffer_if
//   Bit-serial link between the CRC5 stage, the bit stuffer and the NRZI
//   encoder.
//
//   Upstream side (from crc5):
//     s_in, start, endr : data bit plus first-bit and last-bit markers
//     pause             : back-pressure to crc5
//   Downstream side (to NRZI):
//     s_out, start_n, endr_n, valid_n
//
//   Handshake: the upstream presents s_in/start/endr every cycle. A bit is
//   consumed on a rising clk edge when pause was low in the cycle before
//   that edge. While pause is high, the upstream holds s_in/endr/start
//   unchanged. There is no ready signal downstream: the NRZI encoder takes
//   one bit per clock whenever valid_n is high.
//
//   Modports:
//     master : crc5 side / bench driver (drives s_in, start, endr)
//     slave  : the bit stuffer (drives pause and the downstream outputs)
interface usb_bit_stuffer_if;
   logic s_in;
   logic start;
   logic endr;
   logic pause;
   logic s_out;
   logic start_n;
   logic endr_n;
   logic valid_n;

   modport master (
      output s_in, start, endr,
      input  pause, s_out, start_n, endr_n, valid_n
   );

   modport slave (
      input  s_in, start, endr,
      output pause, s_out, start_n, endr_n, valid_n
   );
endinterface

// File: rtl/usb_bit_stuffer.sv
// usb_bit_stuffer
//   Serial USB bit stuffer. It consumes the bit stream coming from crc5 and
//   inserts a 0 after every STUFF_LEN consecutive 1s. While it is emitting
//   an inserted bit it raises pause, so crc5 holds its current bit. Each
//   consumed bit appears on s_out one clock later, framed by start_n and
//   endr_n.
//
//   Ports:
//     clk        clock
//     rst_b      asynchronous active-low reset
//     bus        usb_bit_stuffer_if.slave
//                  inputs:  s_in, start, endr
//                  outputs: pause, s_out, start_n, endr_n, valid_n
//     dbg_state  current FSM state (0=IDLE, 1=XMIT, 2=STUFF)
//
//   Parameters:
//     STUFF_LEN  number of consecutive 1s that trigger one inserted 0 (1..7)
//     CNT_W      width of the ones counter; must be able to hold STUFF_LEN
module usb_bit_stuffer #(
   parameter int STUFF_LEN = 6,
   parameter int CNT_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst_b,
   usb_bit_stuffer_if.slave      bus,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XMIT  = 2'd1,
      STUFF = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   ones_cnt_q,  ones_cnt_d;
   logic               last_pend_q, last_pend_d;
   logic               s_out_q,     s_out_d;
   logic               start_n_q,   start_n_d;
   logic               endr_n_q,    endr_n_d;
   logic               valid_n_q,   valid_n_d;

   // Ones count after the bit being consumed this cycle. A packet's first
   // bit starts counting from zero, so no run of 1s carries across packets.
   logic [CNT_W-1:0]   cnt_next;
   logic               hit_stuff;

   always_comb begin
      cnt_next = '0;
      if (bus.s_in) begin
         if (state_q == XMIT) begin
            cnt_next = ones_cnt_q + CNT_W'(1);
         end else begin
            cnt_next = CNT_W'(1);
         end
      end
   end

   assign hit_stuff = bus.s_in && (cnt_next == CNT_W'(STUFF_LEN));

   // Next-state and output computation.
   always_comb begin
      state_d     = state_q;
      ones_cnt_d  = ones_cnt_q;
      last_pend_d = last_pend_q;
      s_out_d     = 1'b0;
      start_n_d   = 1'b0;
      endr_n_d    = 1'b0;
      valid_n_d   = 1'b0;

      case (state_q)
         IDLE: begin
            ones_cnt_d = '0;
            if (bus.start) begin
               s_out_d    = bus.s_in;
               start_n_d  = 1'b1;
               valid_n_d  = 1'b1;
               ones_cnt_d = cnt_next;
               if (hit_stuff) begin
                  state_d     = STUFF;
                  last_pend_d = bus.endr;
               end else if (bus.endr) begin
                  state_d  = IDLE;
                  endr_n_d = 1'b1;
               end else begin
                  state_d = XMIT;
               end
            end
         end

         XMIT: begin
            // A start seen here is ignored; the packet is still in progress.
            s_out_d    = bus.s_in;
            valid_n_d  = 1'b1;
            ones_cnt_d = cnt_next;
            if (hit_stuff) begin
               state_d     = STUFF;
               last_pend_d = bus.endr;
            end else if (bus.endr) begin
               state_d  = IDLE;
               endr_n_d = 1'b1;
            end else begin
               state_d = XMIT;
            end
         end

         STUFF: begin
            // Upstream is paused and holding its bit. Emit the inserted 0.
            // If the bit that completed the run was the last one, the end
            // marker moves onto this inserted 0.
            valid_n_d   = 1'b1;
            ones_cnt_d  = '0;
            endr_n_d    = last_pend_q;
            last_pend_d = 1'b0;
            state_d     = last_pend_q ? IDLE : XMIT;
         end

         default: begin
            state_d     = IDLE;
            ones_cnt_d  = '0;
            last_pend_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         ones_cnt_q  <= '0;
         last_pend_q <= 1'b0;
         s_out_q     <= 1'b0;
         start_n_q   <= 1'b0;
         endr_n_q    <= 1'b0;
         valid_n_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ones_cnt_q  <= ones_cnt_d;
         last_pend_q <= last_pend_d;
         s_out_q     <= s_out_d;
         start_n_q   <= start_n_d;
         endr_n_q    <= endr_n_d;
         valid_n_q   <= valid_n_d;
      end
   end

   // pause comes straight from the state register, so it is glitch-free and
   // clears at the same moment as an asynchronous reset.
   assign bus.pause   = (state_q == STUFF);
   assign bus.s_out   = s_out_q;
   assign bus.start_n = start_n_q;
   assign bus.endr_n  = endr_n_q;
   assign bus.valid_n = valid_n_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_usb_bit_stuffer.sv
module tb_usb_bit_stuffer;

   localparam int STUFF_LEN = 6;

   logic       clk;
   logic       rst_b;
   logic [1:0] dbg_state;

   usb_bit_stuffer_if bus ();

   usb_bit_stuffer #(.STUFF_LEN(STUFF_LEN), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // Each entry is {s_out, start_n, endr_n} for one expected output bit.
   logic [2:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic       sb_en  = 1'b1;

   always @(negedge clk) begin
      logic [2:0] e;
      if (rst_b && sb_en && bus.valid_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_bit: got {s,st,en}=%b%b%b but nothing was expected",
                     bus.s_out, bus.start_n, bus.endr_n);
         end else begin
            e = exp_q.pop_front();
            if ({bus.s_out, bus.start_n, bus.endr_n} !== e) begin
               errors++;
               $display("FAIL sb_bit: got {s,st,en}=%b%b%b expected %b",
                        bus.s_out, bus.start_n, bus.endr_n, e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Sends one packet, MSB of bits first. Expected output is pushed to the
   // scoreboard up front. Pause cycles are counted and compared against
   // exp_stuffs. Must be called at posedge+1.
   task automatic send_packet(input logic [31:0] bits, input int len,
                              input int exp_stuffs, input string name);
      int   cnt;
      int   pause_cnt;
      int   guard;
      logic b;
      logic was_p;
      logic stuff_here;
      logic [31:0] vec;
      vec = bits;
      cnt = 0;
      for (int i = 0; i < len; i++) begin
         b = vec[len-1-i];
         cnt = b ? cnt + 1 : 0;
         stuff_here = (cnt == STUFF_LEN);
         exp_q.push_back({b, (i == 0), ((i == len-1) && !stuff_here)});
         if (stuff_here) begin
            exp_q.push_back({1'b0, 1'b0, (i == len-1)});
            cnt = 0;
         end
      end

      pause_cnt = 0;
      for (int i = 0; i < len; i++) begin
         b = vec[len-1-i];
         bus.s_in  = b;
         bus.start = (i == 0);
         bus.endr  = (i == len-1);
         guard = 0;
         forever begin
            was_p = bus.pause;
            @(posedge clk);
            #1;
            if (!was_p) break;
            pause_cnt++;
            guard++;
            if (guard > 2) begin
               errors++;
               $display("FAIL %s_pause_stuck: pause high %0d cycles, required at most 1", name, guard);
               break;
            end
         end
         checks++;
         if (bus.s_out !== b || bus.valid_n !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency bit%0d: s_out=%b valid_n=%b, required s_out=%b valid_n=1",
                     name, i, bus.s_out, bus.valid_n, b);
         end
         if (i == 0) begin
            checks++;
            if (bus.start_n !== 1'b1) begin
               errors++;
               $display("FAIL %s_start_n: got %b required 1", name, bus.start_n);
            end
         end
      end
      bus.s_in  = 1'b0;
      bus.start = 1'b0;
      bus.endr  = 1'b0;
      // A trailing stuff shows its pause in the cycle after the last accept.
      if (bus.pause) pause_cnt++;
      checks++;
      if (pause_cnt !== exp_stuffs) begin
         errors++;
         $display("FAIL %s_pause_count: got %0d required %0d", name, pause_cnt, exp_stuffs);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (bus.valid_n !== 1'b0 || bus.pause !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL %s_idle: valid_n=%b pause=%b state=%0d, required 0/0/IDLE",
                  name, bus.valid_n, bus.pause, dbg_state);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_b     = 1'b0;
      bus.s_in  = 1'b0;
      bus.start = 1'b0;
      bus.endr  = 1'b0;
      #12;
      checks++;
      if ({bus.pause, bus.s_out, bus.start_n, bus.endr_n, bus.valid_n} !== 5'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b state=%0d required 00000 state=0",
                  {bus.pause, bus.s_out, bus.start_n, bus.endr_n, bus.valid_n}, dbg_state);
      end
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_stuff();
      send_packet(32'b0000_0001_1111_1111, 16, 1, "t1");
      idle_cycles(1);
      // At this point the trailing 1 carrying endr_n has been seen.
      idle_cycles(1);
      check_idle("t1");
   endtask

   task automatic test_trailing_stuff();
      send_packet(32'b000000_111111, 12, 1, "t2");
      idle_cycles(1);
      checks++;
      if (bus.s_out !== 1'b0 || bus.endr_n !== 1'b1 || bus.valid_n !== 1'b1) begin
         errors++;
         $display("FAIL t2_trailing_zero: s_out=%b endr_n=%b valid_n=%b, required 0/1/1",
                  bus.s_out, bus.endr_n, bus.valid_n);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL t2_state_after: got %0d required 0", dbg_state);
      end
      idle_cycles(1);
      check_idle("t2");
   endtask

   task automatic test_no_stuff();
      send_packet(32'b00_11111_0_11111, 13, 0, "t3");
      idle_cycles(2);
      check_idle("t3");
   endtask

   task automatic test_double_stuff();
      send_packet(32'hFFF, 12, 2, "t4");
      idle_cycles(2);
      check_idle("t4");
   endtask

   task automatic test_reset_in_stuff();
      sb_en     = 1'b0;
      bus.s_in  = 1'b1;
      bus.start = 1'b1;
      bus.endr  = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      idle_cycles(5);
      checks++;
      if (bus.pause !== 1'b1) begin
         errors++;
         $display("FAIL t5_enter_stuff: pause=%b required 1", bus.pause);
      end
      #2;
      rst_b = 1'b0;
      #1;
      checks++;
      if ({bus.pause, bus.s_out, bus.start_n, bus.endr_n, bus.valid_n} !== 5'b0) begin
         errors++;
         $display("FAIL t5_async_clear: got %b required 00000",
                  {bus.pause, bus.s_out, bus.start_n, bus.endr_n, bus.valid_n});
      end
      bus.s_in = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      sb_en = 1'b1;
      send_packet(32'b111110, 6, 0, "t5");
      idle_cycles(2);
      check_idle("t5");
   endtask

   task automatic test_back_to_back();
      send_packet(32'b0011111, 7, 0, "t6a");
      checks++;
      if (bus.endr_n !== 1'b1 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL t6_a_end: endr_n=%b state=%0d, required 1/IDLE", bus.endr_n, dbg_state);
      end
      send_packet(32'b1011, 4, 0, "t6b");
      idle_cycles(2);
      check_idle("t6");
   endtask

   task automatic test_random();
      logic [31:0] v;
      int len;
      int cnt;
      int st;
      for (int p = 0; p < 6; p++) begin
         len = $urandom_range(1, 24);
         v = 32'($urandom_range(0, 32'h7FFF_FFFF)) | (($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 : 32'h0);
         cnt = 0;
         st = 0;
         for (int i = 0; i < len; i++) begin
            cnt = v[len-1-i] ? cnt + 1 : 0;
            if (cnt == STUFF_LEN) begin
               st++;
               cnt = 0;
            end
         end
         send_packet(v, len, st, "rnd");
      end
      idle_cycles(3);
      check_idle("rnd");
   endtask

   initial begin
      test_reset();
      test_single_stuff();
      test_trailing_stuff();
      test_no_stuff();
      test_double_stuff();
      test_reset_in_stuff();
      test_back_to_back();
      test_random();
      idle_cycles(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected bits never appeared, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
